writeback_unit: RTL and testbench

- Producer side of the integer register file write port.
- Collects completed results from the execute stage (valid/ready) and the load unit (valid-only, always accepted).
- Aligns and sign/zero-extends load data, arbitrates between the two sources, and drives a registered rd/write_data/we triple into the register file.
- Keeps a per-register pending scoreboard so decode can stall on RAW hazards against in-flight writes.

---
 rtl/rv_pkg.sv | 16 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/writeback_unit.sv | 136 +++++++++++++
 tb/tb_writeback_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV64 integer datapath types and load encodings
package rv_pkg;

  localparam int XLEN = 64;

  typedef logic [4:0] reg_idx_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with exposed head and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count != FULL) || do_pop);
  assign head_data = mem[rd_ptr];

  // Storage carries no reset: only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - register file write port arbiter with load formatting and pending scoreboard
module writeback_unit #(
  parameter int XLEN          = rv_pkg::XLEN,
  parameter int EX_FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic [2:0]      mem_off,
  input  logic [2:0]      mem_funct3,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            busy_rs1,
  output logic            busy_rs2,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_write_data,
  output logic            load_fmt_err
);

  import rv_pkg::*;

  localparam int AW = $clog2(EX_FIFO_DEPTH);

  function automatic logic [XLEN-1:0] load_format(input logic [XLEN-1:0] data,
                                                  input logic [2:0] off,
                                                  input logic [2:0] funct3);
    logic [XLEN-1:0] s;
    s = data >> {off, 3'b000};
    case (funct3)
      F3_LB:   return {{(XLEN-8){s[7]}}, s[7:0]};
      F3_LH:   return {{(XLEN-16){s[15]}}, s[15:0]};
      F3_LW:   return {{(XLEN-32){s[31]}}, s[31:0]};
      F3_LD:   return s;
      F3_LBU:  return {{(XLEN-8){1'b0}}, s[7:0]};
      F3_LHU:  return {{(XLEN-16){1'b0}}, s[15:0]};
      F3_LWU:  return {{(XLEN-32){1'b0}}, s[31:0]};
      default: return '0;
    endcase
  endfunction

  logic [AW:0]        count;
  logic [XLEN+4:0]    head;
  logic               fifo_empty;
  logic               ex_acc;
  logic               bypass;
  logic               pop;
  logic               push;
  logic               win_valid;
  reg_idx_t           win_rd;
  logic [XLEN-1:0]    win_data;
  logic [31:0]        pending;
  logic [31:0]        pending_next;

  assign ex_ready   = count < (AW+1)'(EX_FIFO_DEPTH);
  assign fifo_empty = (count == '0);
  assign ex_acc     = ex_valid && ex_ready;
  assign bypass     = ex_acc && !mem_valid && fifo_empty;
  assign pop        = !mem_valid && !fifo_empty;
  assign push       = ex_acc && !bypass;

  sync_fifo #(
    .WIDTH (XLEN + 5),
    .DEPTH (EX_FIFO_DEPTH)
  ) u_ex_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({ex_rd, ex_data}),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

  // Loads cannot be stalled, so they always win; queued ex beats keep order ahead of new ones.
  always_comb begin
    win_valid = 1'b0;
    win_rd    = '0;
    win_data  = '0;
    if (mem_valid) begin
      win_valid = 1'b1;
      win_rd    = mem_rd;
      win_data  = load_format(mem_data, mem_off, mem_funct3);
    end else if (!fifo_empty) begin
      win_valid = 1'b1;
      win_rd    = head[XLEN+4:XLEN];
      win_data  = head[XLEN-1:0];
    end else if (bypass) begin
      win_valid = 1'b1;
      win_rd    = ex_rd;
      win_data  = ex_data;
    end
  end

  // Issue is applied after retire so a same-edge set of the same register survives.
  always_comb begin
    pending_next = pending;
    if (win_valid) begin
      pending_next[win_rd] = 1'b0;
    end
    if (iss_valid) begin
      pending_next[iss_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we         <= 1'b0;
      rf_rd         <= '0;
      rf_write_data <= '0;
      load_fmt_err  <= 1'b0;
      pending       <= '0;
    end else begin
      rf_we        <= win_valid && (win_rd != '0);
      load_fmt_err <= mem_valid && (mem_funct3 == 3'b111);
      pending      <= pending_next;
      if (win_valid && (win_rd != '0)) begin
        rf_rd         <= win_rd;
        rf_write_data <= win_data;
      end
    end
  end

  assign busy_rs1 = pending[rs1];
  assign busy_rs2 = pending[rs2];

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - self-checking bench for writeback_unit against a queue-based model
module tb_writeback_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [63:0] ex_data;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic [2:0]  mem_off;
  logic [2:0]  mem_funct3;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        busy_rs1;
  logic        busy_rs2;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [63:0] rf_write_data;
  logic        load_fmt_err;

  int tests = 0;
  int fails = 0;

  writeback_unit #(.XLEN(64), .EX_FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_rd         (ex_rd),
    .ex_data       (ex_data),
    .mem_valid     (mem_valid),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .mem_off       (mem_off),
    .mem_funct3    (mem_funct3),
    .iss_valid     (iss_valid),
    .iss_rd        (iss_rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .busy_rs1      (busy_rs1),
    .busy_rs2      (busy_rs2),
    .rf_we         (rf_we),
    .rf_rd         (rf_rd),
    .rf_write_data (rf_write_data),
    .load_fmt_err  (load_fmt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: loads are formatted with signed casts, ex beats live in plain queues.
  function automatic logic [63:0] m_fmt(input logic [63:0] d, input logic [2:0] off, input logic [2:0] f3);
    logic [63:0] s;
    s = d >> (8 * off);
    case (f3)
      3'd0: return longint'(byte'(s[7:0]));
      3'd1: return longint'(shortint'(s[15:0]));
      3'd2: return longint'(int'(s[31:0]));
      3'd3: return s;
      3'd4: return {56'd0, s[7:0]};
      3'd5: return {48'd0, s[15:0]};
      3'd6: return {32'd0, s[31:0]};
      default: return 64'd0;
    endcase
  endfunction

  logic [4:0]  q_rd [$];
  logic [63:0] q_data [$];
  bit          m_pend [32];
  logic        m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [63:0] m_data = '0;
  logic        m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_rd.delete();
      q_data.delete();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_we = 1'b0;
      m_rd = '0;
      m_data = '0;
      m_err = 1'b0;
    end else begin
      bit          acc;
      bit          win;
      bit          taken;
      logic [4:0]  wrd;
      logic [63:0] wdat;
      acc = ex_valid && (q_rd.size() < DEPTH);
      win = 1'b0;
      taken = 1'b0;
      wrd = '0;
      wdat = '0;
      if (mem_valid) begin
        win = 1'b1;
        wrd = mem_rd;
        wdat = m_fmt(mem_data, mem_off, mem_funct3);
      end else if (q_rd.size() > 0) begin
        win = 1'b1;
        wrd = q_rd.pop_front();
        wdat = q_data.pop_front();
      end else if (acc) begin
        win = 1'b1;
        taken = 1'b1;
        wrd = ex_rd;
        wdat = ex_data;
      end
      if (acc && !taken) begin
        q_rd.push_back(ex_rd);
        q_data.push_back(ex_data);
      end
      m_we = win && (wrd != 0);
      if (m_we) begin
        m_rd = wrd;
        m_data = wdat;
      end
      m_err = mem_valid && (mem_funct3 == 3'b111);
      if (win) m_pend[wrd] = 1'b0;
      if (iss_valid) m_pend[iss_rd] = 1'b1;
      m_pend[0] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rf_we", 64'(rf_we), 64'(m_we));
      chk("rf_rd", 64'(rf_rd), 64'(m_rd));
      chk("rf_write_data", rf_write_data, m_data);
      chk("load_fmt_err", 64'(load_fmt_err), 64'(m_err));
      chk("ex_ready", 64'(ex_ready), 64'(q_rd.size() < DEPTH));
      chk("busy_rs1", 64'(busy_rs1), 64'(m_pend[rs1]));
      chk("busy_rs2", 64'(busy_rs2), 64'(m_pend[rs2]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; mem_valid = 0; iss_valid = 0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [63:0] d, input logic [2:0] off, input logic [2:0] f3);
    mem_valid = 1; mem_rd = rd; mem_data = d; mem_off = off; mem_funct3 = f3;
  endtask

  initial begin
    rst_n = 0;
    ex_valid = 0; ex_rd = 0; ex_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0; mem_off = 0; mem_funct3 = 0;
    iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_we", 64'(rf_we), 64'd0);
    chk("reset_rd", 64'(rf_rd), 64'd0);
    chk("reset_data", rf_write_data, 64'd0);
    chk("reset_ready", 64'(ex_ready), 64'd1);
    rst_n = 1;
    cyc();

    load(5, 64'h0000_0000_8000_0000, 3, 3'b000);
    cyc(); idle();
    chk("lb_we", 64'(rf_we), 64'd1);
    chk("lb_rd", 64'(rf_rd), 64'd5);
    chk("lb_data", rf_write_data, 64'hFFFF_FFFF_FFFF_FF80);
    load(5, 64'h0000_0000_8000_0000, 3, 3'b100);
    cyc(); idle();
    chk("lbu_data", rf_write_data, 64'h0000_0000_0000_0080);

    ex_valid = 1; ex_rd = 3; ex_data = 64'h1234;
    chk("bypass_ready_pre", 64'(ex_ready), 64'd1);
    cyc(); idle();
    chk("bypass_we", 64'(rf_we), 64'd1);
    chk("bypass_rd", 64'(rf_rd), 64'd3);
    chk("bypass_data", rf_write_data, 64'h1234);
    chk("bypass_ready", 64'(ex_ready), 64'd1);

    ex_valid = 1; ex_rd = 7;
    for (int i = 0; i < 3; i++) begin
      load(5'(10 + i), 64'h0123_4567_89AB_CDEF, 0, 3'b011);
      ex_data = 64'(8'hAA + i);
      cyc();
      chk("overlap_load_rd", 64'(rf_rd), 64'(10 + i));
    end
    chk("overlap_ready_low", 64'(ex_ready), 64'd0);
    idle();
    cyc();
    chk("drain0_data", rf_write_data, 64'hAA);
    chk("drain0_rd", 64'(rf_rd), 64'd7);
    cyc();
    chk("drain1_data", rf_write_data, 64'hAB);
    chk("drain_ready", 64'(ex_ready), 64'd1);
    cyc();

    rs1 = 9;
    iss_valid = 1; iss_rd = 9;
    cyc(); idle();
    chk("pend9_set", 64'(busy_rs1), 64'd1);
    cyc();
    chk("pend9_hold", 64'(busy_rs1), 64'd1);
    load(9, 64'h55, 0, 3'b011);
    cyc(); idle();
    chk("pend9_clear", 64'(busy_rs1), 64'd0);
    iss_valid = 1; iss_rd = 9;
    cyc();
    load(9, 64'h66, 0, 3'b011);
    cyc(); idle();
    chk("pend9_set_wins", 64'(busy_rs1), 64'd1);
    load(9, 64'h77, 0, 3'b011);
    cyc(); idle();
    chk("pend9_final", 64'(busy_rs1), 64'd0);

    rs1 = 0;
    ex_valid = 1; ex_rd = 0; ex_data = 64'hDEAD;
    iss_valid = 1; iss_rd = 0;
    cyc(); idle();
    chk("rd0_we", 64'(rf_we), 64'd0);
    chk("rd0_busy", 64'(busy_rs1), 64'd0);
    chk("rd0_keep_data", rf_write_data, 64'h77);

    load(4, 64'hFFFF_FFFF_FFFF_FFFF, 0, 3'b111);
    cyc(); idle();
    chk("fmt_err_pulse", 64'(load_fmt_err), 64'd1);
    chk("fmt_err_data", rf_write_data, 64'd0);
    chk("fmt_err_we", 64'(rf_we), 64'd1);
    cyc();
    chk("fmt_err_clear", 64'(load_fmt_err), 64'd0);

    iss_valid = 1; iss_rd = 20; rs2 = 20;
    ex_valid = 1; ex_rd = 14; ex_data = 64'h1414;
    load(13, 64'h1313, 0, 3'b011);
    cyc();
    iss_valid = 0;
    ex_rd = 15; ex_data = 64'h1515;
    cyc(); idle();
    chk("prereset_ready", 64'(ex_ready), 64'd0);
    #1;
    rst_n = 0;
    #1;
    chk("async_we", 64'(rf_we), 64'd0);
    chk("async_rd", 64'(rf_rd), 64'd0);
    chk("async_data", rf_write_data, 64'd0);
    chk("async_ready", 64'(ex_ready), 64'd1);
    chk("async_busy", 64'(busy_rs2), 64'd0);
    cyc();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post_reset_no_write", 64'(rf_we), 64'd0);
    end

    for (int i = 0; i < 1500; i++) begin
      mem_valid  = ($urandom_range(0, 2) == 0);
      mem_rd     = 5'($urandom);
      mem_data   = {$urandom, $urandom};
      mem_off    = 3'($urandom);
      mem_funct3 = 3'($urandom);
      ex_valid   = $urandom_range(0, 1) == 1;
      ex_rd      = 5'($urandom);
      ex_data    = {$urandom, $urandom};
      iss_valid  = ($urandom_range(0, 3) == 0);
      iss_rd     = 5'($urandom);
      rs1        = 5'($urandom);
      rs2        = 5'($urandom);
      cyc();
    end
    idle();
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
